mips_wb_arbiter: RTL and testbench

//  Write-back arbiter: the writer side of the MIPS register-file write port (wEn/addrW/BusW).

---
 rtl/mips_pkg.sv | 21 ++
 rtl/mips_wb_skid.sv | 73 +++++++
 rtl/mips_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_mips_wb_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the MIPS write-back path.
//   REG_ADDR_W : register-file address width (32 GPRs)
//   DATA_W     : register data width
//   REG_ZERO   : index of the hard-wired zero register
//   wb_req_t   : one pending register write {addr, data}
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage : mips_pkg

// File: rtl/mips_wb_skid.sv
// -----------------------------------------------------------------------------
// mips_wb_skid
// One-entry write-back buffer with a valid/ready input handshake.
// A write aimed at the zero register is accepted and silently dropped.
// The entry may drain and be replaced by a new one in the same cycle.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   in_valid_i     : producer has a result
//   in_ready_o     : buffer can take a result this cycle
//   in_addr_i/_data_i : destination register and result
//   drain_i        : the arbiter is writing this entry out this cycle
//   buf_v_o/_a_o/_d_o : buffered entry (valid, address, data)
// -----------------------------------------------------------------------------
module mips_wb_skid
    import mips_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DW     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [DW-1:0]     in_data_i,
    input  logic              drain_i,
    output logic              buf_v_o,
    output logic [ADDR_W-1:0] buf_a_o,
    output logic [DW-1:0]     buf_d_o
);

    logic              buf_v_q, buf_v_d;
    logic [ADDR_W-1:0] buf_a_q, buf_a_d;
    logic [DW-1:0]     buf_d_q, buf_d_d;
    logic              accept;
    logic              keep;

    // Ready never looks at in_valid_i, so there is no valid->ready path.
    assign in_ready_o = !buf_v_q || drain_i;
    assign accept     = in_valid_i && in_ready_o;
    // Writes to $0 are consumed but never occupy the buffer.
    assign keep       = accept && (in_addr_i != ADDR_W'(REG_ZERO));

    always_comb begin
        buf_v_d = buf_v_q;
        buf_a_d = buf_a_q;
        buf_d_d = buf_d_q;
        if (keep) begin
            buf_v_d = 1'b1;
            buf_a_d = in_addr_i;
            buf_d_d = in_data_i;
        end else if (drain_i) begin
            buf_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v_q <= 1'b0;
            buf_a_q <= '0;
            buf_d_q <= '0;
        end else begin
            buf_v_q <= buf_v_d;
            buf_a_q <= buf_a_d;
            buf_d_q <= buf_d_d;
        end
    end

    assign buf_v_o = buf_v_q;
    assign buf_a_o = buf_a_q;
    assign buf_d_o = buf_d_q;

endmodule : mips_wb_skid

// File: rtl/mips_wb_arbiter.sv
// -----------------------------------------------------------------------------
// mips_wb_arbiter
// Write-back arbiter feeding the register-file write port. Two producers
// (src0 = ALU, src1 = MEM/MULDIV) each own a one-entry buffer; one buffered
// result per cycle is written through a registered output (wEn/addrW/BusW).
// Contention is resolved round-robin. Pending writes (buffers and the output
// register) are reported to the hazard unit for two decode-stage queries.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   s0_valid/ready/addr/data    : ALU result handshake
//   s1_valid/ready/addr/data    : MEM/MULDIV result handshake
//   wb_hold                     : freeze write-back (no grant)
//   wEn, addrW, BusW            : registered register-file write port
//   hz_addrA/B, hz_hitA/B       : hazard queries and pending-write hits
// -----------------------------------------------------------------------------
module mips_wb_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              wb_hold,
    output logic              wEn,
    output logic [ADDR_W-1:0] addrW,
    output logic [DATA_W-1:0] BusW,
    input  logic [ADDR_W-1:0] hz_addrA,
    input  logic [ADDR_W-1:0] hz_addrB,
    output logic              hz_hitA,
    output logic              hz_hitB
);

    logic [1:0]              in_valid;
    logic [1:0]              in_ready;
    logic [ADDR_W-1:0]       in_addr [2];
    logic [DATA_W-1:0]       in_data [2];
    logic [1:0]              buf_v;
    logic [ADDR_W-1:0]       buf_a   [2];
    logic [DATA_W-1:0]       buf_d   [2];
    logic [1:0]              gnt;
    logic                    gnt_any;
    logic                    contend;

    logic                    rr_last_q, rr_last_d;
    logic                    wen_q;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       data_q, data_d;

    assign in_valid   = {s1_valid, s0_valid};
    assign in_addr[0] = s0_addr;
    assign in_addr[1] = s1_addr;
    assign in_data[0] = s0_data;
    assign in_data[1] = s1_data;
    assign s0_ready   = in_ready[0];
    assign s1_ready   = in_ready[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            mips_wb_skid #(
                .ADDR_W (ADDR_W),
                .DW     (DATA_W)
            ) u_skid (
                .clk        (clk),
                .rst        (rst),
                .in_valid_i (in_valid[gi]),
                .in_ready_o (in_ready[gi]),
                .in_addr_i  (in_addr[gi]),
                .in_data_i  (in_data[gi]),
                .drain_i    (gnt[gi]),
                .buf_v_o    (buf_v[gi]),
                .buf_a_o    (buf_a[gi]),
                .buf_d_o    (buf_d[gi])
            );
        end
    endgenerate

    // Round-robin: under contention the source that did not win last time
    // is granted. rr_last only moves when both sources were competing.
    assign contend = !wb_hold && buf_v[0] && buf_v[1];
    assign gnt[0]  = !wb_hold && buf_v[0] && (!buf_v[1] ||  rr_last_q);
    assign gnt[1]  = !wb_hold && buf_v[1] && (!buf_v[0] || !rr_last_q);
    assign gnt_any = gnt[0] || gnt[1];

    always_comb begin
        rr_last_d = rr_last_q;
        addr_d    = addr_q;
        data_d    = data_q;
        if (contend) begin
            rr_last_d = gnt[1];
        end
        if (gnt[1]) begin
            addr_d = buf_a[1];
            data_d = buf_d[1];
        end else if (gnt[0]) begin
            addr_d = buf_a[0];
            data_d = buf_d[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            wen_q     <= gnt_any;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign wEn   = wen_q;
    assign addrW = addr_q;
    assign BusW  = data_q;

    // A result is still in flight while it sits in a buffer or in the
    // output register (the register file takes it at the next edge).
    function automatic logic pending_hit(input logic [ADDR_W-1:0] q,
                                         input logic [1:0]        bv,
                                         input logic [ADDR_W-1:0] a0,
                                         input logic [ADDR_W-1:0] a1,
                                         input logic              we,
                                         input logic [ADDR_W-1:0] aw);
        return (q != ADDR_W'(REG_ZERO)) &&
               ((bv[0] && (a0 == q)) || (bv[1] && (a1 == q)) || (we && (aw == q)));
    endfunction

    assign hz_hitA = pending_hit(hz_addrA, buf_v, buf_a[0], buf_a[1], wen_q, addr_q);
    assign hz_hitB = pending_hit(hz_addrB, buf_v, buf_a[0], buf_a[1], wen_q, addr_q);

endmodule : mips_wb_arbiter

// File: tb/tb_mips_wb_arbiter.sv
module tb_mips_wb_arbiter;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s0_ready, s1_valid, s1_ready;
    logic [4:0]  s0_addr, s1_addr, addrW, hz_addrA, hz_addrB;
    logic [31:0] s0_data, s1_data, BusW;
    logic        wb_hold, wEn, hz_hitA, hz_hitB;

    int checks = 0;
    int errors = 0;

    wb_req_t     sb [$];
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    mips_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s0_addr  (s0_addr),
        .s0_data  (s0_data),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_addr  (s1_addr),
        .s1_data  (s1_data),
        .wb_hold  (wb_hold),
        .wEn      (wEn),
        .addrW    (addrW),
        .BusW     (BusW),
        .hz_addrA (hz_addrA),
        .hz_addrB (hz_addrB),
        .hz_hitA  (hz_hitA),
        .hz_hitB  (hz_hitB)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Register-file model: the write lands at the edge after wEn is seen.
    always @(posedge clk) begin
        if (wEn === 1'b1 && addrW != 5'd0)
            rf[addrW] <= BusW;
    end

    // Scoreboard consumer: every write-port transaction must match the next
    // expected entry.
    always @(negedge clk) begin
        if (wEn === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {27'd0, addrW}, 32'hFFFF_FFFF);
            end else begin
                wb_req_t e;
                e = sb.pop_front();
                $display("WB write addr=%0d data=%08h (expected addr=%0d data=%08h)",
                         addrW, BusW, e.addr, e.data);
                check("wb_addr", {27'd0, addrW}, {27'd0, e.addr});
                check("wb_data", BusW, e.data);
            end
        end
        // Same destination must never be offered by both sources at once.
        if (s0_valid === 1'b1 && s1_valid === 1'b1 && s0_addr == s1_addr && s0_addr != 5'd0)
            check("waw_upstream", 32'd1, 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic wb_req_t req(input logic [4:0] a, input logic [31:0] d);
        wb_req_t r;
        r.addr = a;
        r.data = d;
        return r;
    endfunction

    initial begin
        int i0, i1, cyc, first, last;
        bit acc0, acc1, done;

        rst = 1'b1; wb_hold = 1'b0;
        s0_valid = 1'b0; s0_addr = '0; s0_data = '0;
        s1_valid = 1'b0; s1_addr = '0; s1_data = '0;
        hz_addrA = '0; hz_addrB = '0;
        for (int k = 0; k < 32; k++) rf[k] = 32'd0;

        // ---- 1: reset ----
        step(); step();
        rst = 1'b0;
        step();
        check("rst_wEn",   {31'd0, wEn}, 32'd0);
        check("rst_addrW", {27'd0, addrW}, 32'd0);
        check("rst_BusW",  BusW, 32'd0);
        check("rst_s0_ready", {31'd0, s0_ready}, 32'd1);
        check("rst_s1_ready", {31'd0, s1_ready}, 32'd1);

        // ---- 2: single write, latency ----
        s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'h1234_5678;
        sb.push_back(req(5'd5, 32'h1234_5678));
        step();                               // edge N: accepted
        s0_valid = 1'b0;
        check("lat_wEn_N", {31'd0, wEn}, 32'd0);
        step();                               // edge N+1: registered
        check("lat_wEn_N1", {31'd0, wEn}, 32'd1);
        check("lat_addrW",  {27'd0, addrW}, 32'd5);
        check("lat_BusW",   BusW, 32'h1234_5678);
        step();                               // edge N+2: rf written
        check("rf_r5", rf[5], 32'h1234_5678);
        check("lat_wEn_N2", {31'd0, wEn}, 32'd0);

        // ---- 3: contention, alternating grants src1, src0, ... ----
        for (int k = 0; k < 4; k++) begin
            sb.push_back(req(5'(24 + k), 32'hB000_0000 + k));
            sb.push_back(req(5'(16 + k), 32'hA000_0000 + k));
        end
        i0 = 0; i1 = 0; cyc = 0; first = -1; last = -1; done = 1'b0;
        s0_valid = 1'b1; s0_addr = 5'd16; s0_data = 32'hA000_0000;
        s1_valid = 1'b1; s1_addr = 5'd24; s1_data = 32'hB000_0000;
        for (int t = 0; t < 40 && !done; t++) begin
            if (cyc >= 1 && s0_valid && s1_valid) begin
                check("rr_s1_ready", {31'd0, s1_ready}, {31'd0, cyc[0]});
                check("rr_s0_ready", {31'd0, s0_ready}, {31'd0, ~cyc[0]});
            end
            acc0 = s0_valid && s0_ready;
            acc1 = s1_valid && s1_ready;
            step();
            cyc++;
            if (acc0) i0++;
            if (acc1) i1++;
            if (wEn) begin
                if (first < 0) first = cyc;
                last = cyc;
            end
            s0_valid = (i0 < 4); s0_addr = 5'(16 + i0); s0_data = 32'hA000_0000 + i0;
            s1_valid = (i1 < 4); s1_addr = 5'(24 + i1); s1_data = 32'hB000_0000 + i1;
            if (i0 == 4 && i1 == 4 && sb.size() == 0 && !wEn) done = 1'b1;
        end
        check("rr_completed", {31'd0, done}, 32'd1);
        check("rr_back_to_back", last - first + 1, 32'd8);
        check("rr_first_write_cyc", first, 32'd2);
        s0_valid = 1'b0; s1_valid = 1'b0;

        // ---- 4: write to $0 is dropped ----
        hz_addrA = 5'd0;
        s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'hFFFF_FFFF;
        check("z_s1_ready_pre", {31'd0, s1_ready}, 32'd1);
        step();
        s1_valid = 1'b0;
        check("z_s1_ready_post", {31'd0, s1_ready}, 32'd1);
        check("z_hitA", {31'd0, hz_hitA}, 32'd0);
        repeat (3) begin
            step();
            check("z_wEn", {31'd0, wEn}, 32'd0);
        end
        check("z_s1_ready_end", {31'd0, s1_ready}, 32'd1);

        // Brief reset so the round-robin pointer is known (src1 first).
        rst = 1'b1;
        step();
        rst = 1'b0;

        // ---- 5: wb_hold with both buffers full ----
        wb_hold = 1'b1;
        s0_valid = 1'b1; s0_addr = 5'd10; s0_data = 32'h0A0A_0A0A;
        s1_valid = 1'b1; s1_addr = 5'd11; s1_data = 32'h0B0B_0B0B;
        sb.push_back(req(5'd11, 32'h0B0B_0B0B));
        sb.push_back(req(5'd10, 32'h0A0A_0A0A));
        step();
        s0_valid = 1'b0; s1_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("hold_s0_ready", {31'd0, s0_ready}, 32'd0);
            check("hold_s1_ready", {31'd0, s1_ready}, 32'd0);
            step();
            check("hold_wEn", {31'd0, wEn}, 32'd0);
        end
        wb_hold = 1'b0;
        step();
        check("rel_first_wEn",  {31'd0, wEn}, 32'd1);
        check("rel_first_addr", {27'd0, addrW}, 32'd11);
        step();
        check("rel_second_addr", {27'd0, addrW}, 32'd10);
        step();
        check("rel_idle_wEn", {31'd0, wEn}, 32'd0);

        // ---- 6: hazard tracking, then reset mid-flight ----
        hz_addrA = 5'd9; hz_addrB = 5'd3;
        s0_valid = 1'b1; s0_addr = 5'd9; s0_data = 32'h0909_0909;
        sb.push_back(req(5'd9, 32'h0909_0909));
        check("hz_input_not_matched", {31'd0, hz_hitA}, 32'd0);
        step();
        s0_valid = 1'b0;
        check("hz_buffered_hitA", {31'd0, hz_hitA}, 32'd1);
        check("hz_buffered_hitB", {31'd0, hz_hitB}, 32'd0);
        step();
        check("hz_outreg_wEn",  {31'd0, wEn}, 32'd1);
        check("hz_outreg_hitA", {31'd0, hz_hitA}, 32'd1);
        step();
        check("hz_after_hitA", {31'd0, hz_hitA}, 32'd0);

        wb_hold = 1'b1;
        hz_addrA = 5'd7; hz_addrB = 5'd8;
        s0_valid = 1'b1; s0_addr = 5'd7; s0_data = 32'h0707_0707;
        s1_valid = 1'b1; s1_addr = 5'd8; s1_data = 32'h0808_0808;
        step();
        s0_valid = 1'b0; s1_valid = 1'b0;
        check("hz_full_hitA", {31'd0, hz_hitA}, 32'd1);
        check("hz_full_hitB", {31'd0, hz_hitB}, 32'd1);
        rst = 1'b1; wb_hold = 1'b0;
        step();
        check("mrst_hitA",  {31'd0, hz_hitA}, 32'd0);
        check("mrst_hitB",  {31'd0, hz_hitB}, 32'd0);
        check("mrst_wEn",   {31'd0, wEn}, 32'd0);
        check("mrst_addrW", {27'd0, addrW}, 32'd0);
        rst = 1'b0;
        repeat (3) begin
            step();
            check("mrst_no_write", {31'd0, wEn}, 32'd0);
        end
        check("rf_r7_untouched", rf[7], 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mips_wb_arbiter
